// File: rtl/ccc_pkg.sv
// Shared types, defaults and helpers for the CCC lock sequencer.
package ccc_pkg;

    // Sequencer states: wait for lock, qualify it, run, hold reset after a loss.
    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_QUAL = 2'd1,
        S_RUN  = 2'd2,
        S_HOLD = 2'd3
    } ccc_state_e;

    localparam int unsigned DefSyncStages   = 2;
    localparam int unsigned DefQualCycles   = 1024;
    localparam int unsigned DefHoldCycles   = 16;
    localparam int unsigned DefCntW         = 16;
    localparam int unsigned DefTimeoutCycles = 65535;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/ccc_sync_bit.sv
// Multi-flop synchronizer for one asynchronous level; flops clear to 0 on reset.
module ccc_sync_bit
    import ccc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefSyncStages
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ccc_lock_sequencer.sv
// Qualifies the CCC lock indications into a glitch-free fabric reset and lock status.
// Optional acquisition timeout flag enabled by defining CCC_LOCK_TIMEOUT_EN.
module ccc_lock_sequencer
    import ccc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = DefSyncStages,
    parameter int unsigned QUAL_CYCLES    = DefQualCycles,
    parameter int unsigned HOLD_CYCLES    = DefHoldCycles,
    parameter int unsigned CNT_W          = DefCntW,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic             FAB_CLK,
    input  logic             M2F_RESET_N,
    input  logic             FAB_LOCK,
    input  logic             MSS_LOCK,
    input  logic             clr_stats,
    output logic             fab_rst_n,
    output logic             lock_stable,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic             lock_timeout
);

    localparam int unsigned QualW = (QUAL_CYCLES > 1) ? $clog2(QUAL_CYCLES) : 1;
    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [QualW-1:0] QualLast = QualW'(QUAL_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [31:0] CntMax = (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);

    // Reject parameter values the counters and synchronizers cannot represent.
    if (SYNC_STAGES < 2) begin : gen_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (QUAL_CYCLES < 1 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : gen_bad_cycles
        $error("QUAL_CYCLES, HOLD_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : gen_bad_cnt
        $error("CNT_W must be in 1..32");
    end

    logic fab_lock_s, mss_lock_s, lock_s;

    ccc_sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_fab (
        .clk_i  (FAB_CLK),
        .rst_ni (M2F_RESET_N),
        .d_i    (FAB_LOCK),
        .q_o    (fab_lock_s)
    );

    ccc_sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_mss (
        .clk_i  (FAB_CLK),
        .rst_ni (M2F_RESET_N),
        .d_i    (MSS_LOCK),
        .q_o    (mss_lock_s)
    );

    assign lock_s = fab_lock_s & mss_lock_s;

    ccc_state_e       state_q, state_d;
    logic [QualW-1:0] qual_cnt_q, qual_cnt_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic             loss_evt;
    logic             rst_out_q, stable_q;

    // Next-state logic: qualify lock, run, and hold reset for a minimum time after a loss.
    always_comb begin
        state_d    = state_q;
        qual_cnt_d = qual_cnt_q;
        hold_cnt_d = hold_cnt_q;
        loss_evt   = 1'b0;
        unique case (state_q)
            S_WAIT: begin
                qual_cnt_d = '0;
                if (lock_s) begin
                    state_d = S_QUAL;
                end
            end
            S_QUAL: begin
                if (!lock_s) begin
                    // Any glitch restarts qualification from scratch.
                    state_d    = S_WAIT;
                    qual_cnt_d = '0;
                end else if (qual_cnt_q == QualLast) begin
                    state_d    = S_RUN;
                    qual_cnt_d = '0;
                end else begin
                    qual_cnt_d = qual_cnt_q + QualW'(1);
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                    loss_evt   = 1'b1;
                end
            end
            S_HOLD: begin
                // Lock is ignored here so a bouncing PLL cannot shorten the hold.
                if (hold_cnt_q == HoldLast) begin
                    state_d    = S_WAIT;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HoldW'(1);
                end
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    // Loss counter: a loss event wins over a coincident clear and leaves a count of one.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (loss_evt) begin
            loss_cnt_d = clr_stats ? CNT_W'(1) : CNT_W'(sat_inc(32'(loss_cnt_q), CntMax));
        end else if (clr_stats) begin
            loss_cnt_d = '0;
        end
    end

    // State, counters and registered outputs; outputs track the next state.
    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            state_q    <= S_WAIT;
            qual_cnt_q <= '0;
            hold_cnt_q <= '0;
            loss_cnt_q <= '0;
            rst_out_q  <= 1'b0;
            stable_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            qual_cnt_q <= qual_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            loss_cnt_q <= loss_cnt_d;
            rst_out_q  <= (state_d == S_RUN);
            stable_q   <= (state_d == S_RUN);
        end
    end

    assign fab_rst_n     = rst_out_q;
    assign lock_stable   = stable_q;
    assign lock_loss_cnt = loss_cnt_q;

`ifdef CCC_LOCK_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            tmo_flag_q, tmo_flag_d;

    // Timeout runs while acquiring, saturates, and is cleared only by entering RUN.
    always_comb begin
        tmo_cnt_d  = tmo_cnt_q;
        tmo_flag_d = tmo_flag_q;
        if (state_d == S_RUN) begin
            tmo_cnt_d  = '0;
            tmo_flag_d = 1'b0;
        end else if (state_q == S_WAIT || state_q == S_QUAL) begin
            if (tmo_cnt_q != TmoLast) begin
                tmo_cnt_d = tmo_cnt_q + TmoW'(1);
            end
            if (tmo_cnt_d == TmoLast) begin
                tmo_flag_d = 1'b1;
            end
        end
    end

    // Timeout counter and sticky flag registers.
    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign lock_timeout = tmo_flag_q;
`else
    assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ccc_lock_sequencer.sv
// Directed scoreboard bench for ccc_lock_sequencer (SYNC=2, QUAL=8, HOLD=4, CNT_W=2).
module tb_ccc_lock_sequencer;

    localparam int unsigned SyncStages = 2;
    localparam int unsigned QualCycles = 8;
    localparam int unsigned HoldCycles = 4;
    localparam int unsigned CntW       = 2;
    localparam int unsigned TmoCycles  = 100;

    logic            FAB_CLK     = 1'b0;
    logic            M2F_RESET_N = 1'b1;
    logic            FAB_LOCK    = 1'b0;
    logic            MSS_LOCK    = 1'b0;
    logic            clr_stats   = 1'b0;
    logic            fab_rst_n;
    logic            lock_stable;
    logic [CntW-1:0] lock_loss_cnt;
    logic            lock_timeout;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 FAB_CLK = ~FAB_CLK;

    ccc_lock_sequencer #(
        .SYNC_STAGES    (SyncStages),
        .QUAL_CYCLES    (QualCycles),
        .HOLD_CYCLES    (HoldCycles),
        .CNT_W          (CntW),
        .TIMEOUT_CYCLES (TmoCycles)
    ) dut (
        .FAB_CLK       (FAB_CLK),
        .M2F_RESET_N   (M2F_RESET_N),
        .FAB_LOCK      (FAB_LOCK),
        .MSS_LOCK      (MSS_LOCK),
        .clr_stats     (clr_stats),
        .fab_rst_n     (fab_rst_n),
        .lock_stable   (lock_stable),
        .lock_loss_cnt (lock_loss_cnt),
        .lock_timeout  (lock_timeout)
    );

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0d, nothing expected", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0d required %0d", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance n rising edges and land 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge FAB_CLK);
        #1;
    endtask

    // Count edges until fab_rst_n reaches target, starting from edge count start.
    task automatic wait_rst(input logic target, input int start, input int limit,
                            output int edges);
        edges = start;
        while (fab_rst_n !== target && edges < limit) begin
            tick(1);
            edges++;
        end
    endtask

    // One-cycle MSS_LOCK dip in RUN, then wait out hold plus requalification.
    task automatic loss_cycle(input logic [31:0] exp_cnt, input bit with_clr);
        int e;
        push_exp("loss_to_rst_fall_edges", 3);
        MSS_LOCK = 1'b0;
        tick(1);
        MSS_LOCK = 1'b1;
        e = 1;
        if (with_clr) begin
            tick(1);
            e++;
            clr_stats = 1'b1;
        end
        wait_rst(1'b0, e, 40, e);
        clr_stats = 1'b0;
        check(32'(e));
        push_exp("loss_cnt", exp_cnt);
        check(32'(lock_loss_cnt));
        push_exp("loss_to_rst_rise_edges", 16);
        wait_rst(1'b1, e, 60, e);
        check(32'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;

        // Asynchronous reset assertion before any clock edge.
        #2 M2F_RESET_N = 1'b0;
        #1;
        push_exp("reset_fab_rst_n", 0);
        check(32'(fab_rst_n));
        push_exp("reset_lock_stable", 0);
        check(32'(lock_stable));
        push_exp("reset_loss_cnt", 0);
        check(32'(lock_loss_cnt));
        push_exp("reset_lock_timeout", 0);
        check(32'(lock_timeout));
        tick(3);
        #3 M2F_RESET_N = 1'b1;
        tick(3);

        // Acquire with a one-cycle FAB_LOCK glitch while qual_cnt is 5.
        FAB_LOCK = 1'b1;
        MSS_LOCK = 1'b1;
        tick(6);
        FAB_LOCK = 1'b0;
        tick(1);
        FAB_LOCK = 1'b1;
        push_exp("glitch_requal_edges", 18);
        wait_rst(1'b1, 7, 60, e);
        check(32'(e));
        push_exp("glitch_lock_stable", 1);
        check(32'(lock_stable));
        push_exp("glitch_loss_cnt", 0);
        check(32'(lock_loss_cnt));

        // Losses in RUN: count climbs and saturates at 3.
        loss_cycle(1, 1'b0);
        loss_cycle(2, 1'b0);
        loss_cycle(3, 1'b0);
        loss_cycle(3, 1'b0);
        loss_cycle(3, 1'b0);

        // Clear coincident with a loss: the loss wins.
        loss_cycle(1, 1'b1);

        // Clear alone.
        clr_stats = 1'b1;
        tick(1);
        clr_stats = 1'b0;
        push_exp("clr_alone_cnt", 0);
        check(32'(lock_loss_cnt));
        push_exp("clr_alone_stable", 1);
        check(32'(lock_stable));
        loss_cycle(1, 1'b0);

        // Asynchronous reset mid-RUN between edges.
        tick(2);
        #3 M2F_RESET_N = 1'b0;
        #1;
        push_exp("async_fab_rst_n", 0);
        check(32'(fab_rst_n));
        push_exp("async_lock_stable", 0);
        check(32'(lock_stable));
        push_exp("async_loss_cnt", 0);
        check(32'(lock_loss_cnt));

        // Restart with locks low; exercise the acquisition timeout.
        FAB_LOCK = 1'b0;
        MSS_LOCK = 1'b0;
        tick(2);
        #3 M2F_RESET_N = 1'b1;
        tick(99);
`ifdef CCC_LOCK_TIMEOUT_EN
        push_exp("timeout_before", 0);
        check(32'(lock_timeout));
        tick(1);
        push_exp("timeout_at_limit", 1);
        check(32'(lock_timeout));
        tick(30);
        push_exp("timeout_sticky", 1);
        check(32'(lock_timeout));
`else
        tick(31);
        push_exp("timeout_disabled", 0);
        check(32'(lock_timeout));
`endif
        FAB_LOCK = 1'b1;
        MSS_LOCK = 1'b1;
        push_exp("clean_acquire_edges", 11);
        wait_rst(1'b1, 0, 40, e);
        check(32'(e));
        push_exp("clean_lock_stable", 1);
        check(32'(lock_stable));
        push_exp("clean_loss_cnt", 0);
        check(32'(lock_loss_cnt));
        push_exp("run_lock_timeout", 0);
        check(32'(lock_timeout));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
